// File: rtl/gddr6_bank_timing_checker.sv
// GDDR6 per-channel bank timing checker: tracks IDLE/ACTIVE per bank and elapsed-cycle
// counters, and reports protocol/timing violations on already-decoded commands.
module gddr6_bank_timing_checker #(
  parameter int unsigned BANK_NUM = 16,
  parameter int unsigned BANK_W   = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned T_RCD    = 12,
  parameter int unsigned T_RP     = 12,
  parameter int unsigned T_RAS    = 28,
  parameter int unsigned T_RRD    = 4,
  parameter int unsigned T_CCD_S  = 2,
  parameter int unsigned T_CCD_L  = 4,
  parameter int unsigned ERRCNT_W = 16
) (
  input  logic                CLK_t,
  input  logic                RESET_n,
  input  logic                cmd_valid,
  input  logic [4:0]          cmd_code,
  input  logic [BANK_W-1:0]   cmd_bank,
  input  logic                bg_en,
  input  logic                err_clr,
  output logic                err_valid,
  output logic [2:0]          err_code,
  output logic [BANK_W-1:0]   err_bank,
  output logic [6:0]          err_status,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int unsigned BG_NUM = BANK_NUM / 4;
  localparam int unsigned BG_W   = BANK_W - 2;

  localparam logic [4:0] CmdAct   = 5'b00100;
  localparam logic [4:0] CmdRd    = 5'b00101;
  localparam logic [4:0] CmdRda   = 5'b00110;
  localparam logic [4:0] CmdWom   = 5'b01001;
  localparam logic [4:0] CmdWoma  = 5'b01010;
  localparam logic [4:0] CmdPrepb = 5'b10000;
  localparam logic [4:0] CmdPreab = 5'b10001;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRcd   = CNT_W'(T_RCD);
  localparam logic [CNT_W-1:0] TRp    = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] TRas   = CNT_W'(T_RAS);
  localparam logic [CNT_W-1:0] TRrd   = CNT_W'(T_RRD);
  localparam logic [CNT_W-1:0] TCcdS  = CNT_W'(T_CCD_S);
  localparam logic [CNT_W-1:0] TCcdL  = CNT_W'(T_CCD_L);

  typedef enum logic {BankIdle, BankActive} bank_st_e;

  bank_st_e             bank_q      [BANK_NUM];
  bank_st_e             bank_d      [BANK_NUM];
  logic [CNT_W-1:0]     e_act_q     [BANK_NUM];
  logic [CNT_W-1:0]     e_act_d     [BANK_NUM];
  logic [CNT_W-1:0]     e_pre_q     [BANK_NUM];
  logic [CNT_W-1:0]     e_pre_d     [BANK_NUM];
  logic [CNT_W-1:0]     e_col_bg_q  [BG_NUM];
  logic [CNT_W-1:0]     e_col_bg_d  [BG_NUM];
  logic [CNT_W-1:0]     e_col_q, e_col_d;
  logic [CNT_W-1:0]     e_act_any_q, e_act_any_d;
  logic [BANK_W-1:0]    last_act_bank_q, last_act_bank_d;

  logic                 err_valid_d;
  logic [2:0]           err_code_d;
  logic [BANK_W-1:0]    err_bank_d;
  logic [6:0]           err_status_d;
  logic [ERRCNT_W-1:0]  err_count_d;

  logic [6:0]           viol;
  logic [BANK_W-1:0]    off_bank;
  logic [BG_W-1:0]      grp;
  logic                 is_act, is_col, is_auto, is_prepb, is_preab;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  assign grp      = cmd_bank[BANK_W-1:2];
  assign is_act   = cmd_valid && (cmd_code == CmdAct);
  assign is_auto  = cmd_valid && (cmd_code == CmdRda || cmd_code == CmdWoma);
  assign is_col   = is_auto || (cmd_valid && (cmd_code == CmdRd || cmd_code == CmdWom));
  assign is_prepb = cmd_valid && (cmd_code == CmdPrepb);
  assign is_preab = cmd_valid && (cmd_code == CmdPreab);

  always_comb begin
    viol            = '0;
    off_bank        = cmd_bank;
    e_col_d         = sat_inc(e_col_q);
    e_act_any_d     = sat_inc(e_act_any_q);
    last_act_bank_d = last_act_bank_q;
    for (int b = 0; b < BANK_NUM; b++) begin
      bank_d[b]  = bank_q[b];
      e_act_d[b] = sat_inc(e_act_q[b]);
      e_pre_d[b] = sat_inc(e_pre_q[b]);
    end
    for (int g = 0; g < BG_NUM; g++) begin
      e_col_bg_d[g] = sat_inc(e_col_bg_q[g]);
    end

    if (is_col) begin
      if (bank_q[cmd_bank] != BankActive) viol[1] = 1'b1;
      if (e_act_q[cmd_bank] < TRcd) viol[2] = 1'b1;
      if (e_col_q < TCcdS || (bg_en && e_col_bg_q[grp] < TCcdL)) viol[3] = 1'b1;
      e_col_d         = CntOne;
      e_col_bg_d[grp] = CntOne;
      if (is_auto) begin
        bank_d[cmd_bank]  = BankIdle;
        e_pre_d[cmd_bank] = CntOne;
      end
    end

    if (is_act) begin
      if (bank_q[cmd_bank] == BankActive) viol[1] = 1'b1;
      if (e_pre_q[cmd_bank] < TRp) viol[4] = 1'b1;
      if (cmd_bank != last_act_bank_q && e_act_any_q < TRrd) viol[6] = 1'b1;
      bank_d[cmd_bank]  = BankActive;
      e_act_d[cmd_bank] = CntOne;
      e_act_any_d       = CntOne;
      last_act_bank_d   = cmd_bank;
    end

    // A PRE to an IDLE bank is a NOP and must not restart its tRP window.
    if (is_prepb && bank_q[cmd_bank] == BankActive) begin
      if (e_act_q[cmd_bank] < TRas) viol[5] = 1'b1;
      bank_d[cmd_bank]  = BankIdle;
      e_pre_d[cmd_bank] = CntOne;
    end

    // Walk downwards so the last hit recorded is the lowest offending bank.
    if (is_preab) begin
      for (int b = BANK_NUM - 1; b >= 0; b--) begin
        if (bank_q[b] == BankActive) begin
          if (e_act_q[b] < TRas) begin
            viol[5]  = 1'b1;
            off_bank = BANK_W'(b);
          end
          bank_d[b]  = BankIdle;
          e_pre_d[b] = CntOne;
        end
      end
    end

    err_valid_d = |viol;
    err_code_d  = 3'd0;
    for (int i = 6; i >= 1; i--) begin
      if (viol[i]) err_code_d = 3'(i);
    end
    err_bank_d = err_valid_d ? off_bank : '0;

    // A violation in the clearing cycle survives the clear.
    if (err_clr) begin
      err_status_d = viol;
      err_count_d  = err_valid_d ? ERRCNT_W'(1) : '0;
    end else begin
      err_status_d = err_status | viol;
      err_count_d  = err_count;
      if (err_valid_d && err_count != '1) err_count_d = err_count + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge CLK_t or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        bank_q[b]  <= BankIdle;
        e_act_q[b] <= CntMax;
        e_pre_q[b] <= CntMax;
      end
      for (int g = 0; g < BG_NUM; g++) begin
        e_col_bg_q[g] <= CntMax;
      end
      e_col_q         <= CntMax;
      e_act_any_q     <= CntMax;
      last_act_bank_q <= '0;
      err_valid       <= 1'b0;
      err_code        <= 3'd0;
      err_bank        <= '0;
      err_status      <= '0;
      err_count       <= '0;
    end else begin
      for (int b = 0; b < BANK_NUM; b++) begin
        bank_q[b]  <= bank_d[b];
        e_act_q[b] <= e_act_d[b];
        e_pre_q[b] <= e_pre_d[b];
      end
      for (int g = 0; g < BG_NUM; g++) begin
        e_col_bg_q[g] <= e_col_bg_d[g];
      end
      e_col_q         <= e_col_d;
      e_act_any_q     <= e_act_any_d;
      last_act_bank_q <= last_act_bank_d;
      err_valid       <= err_valid_d;
      err_code        <= err_code_d;
      err_bank        <= err_bank_d;
      err_status      <= err_status_d;
      err_count       <= err_count_d;
    end
  end

endmodule

// File: tb/tb_gddr6_bank_timing_checker.sv
// Bench for gddr6_bank_timing_checker: directed vector table, hand-written reset/clear
// sequences, and random commands checked against a timestamp-based reference model.
module tb_gddr6_bank_timing_checker;

  localparam int T_RCD = 12, T_RP = 12, T_RAS = 28, T_RRD = 4, T_CCD_S = 2, T_CCD_L = 4;
  localparam int NB = 16;
  localparam int NONE = -1000000;

  localparam logic [4:0] ACT = 5'b00100, RD = 5'b00101, RDA = 5'b00110, WOM = 5'b01001;
  localparam logic [4:0] WOMA = 5'b01010, PRE = 5'b10000, PREA = 5'b10001, NOP = 5'b00000;

  logic        CLK_t = 1'b0;
  logic        RESET_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [4:0]  cmd_code = '0;
  logic [3:0]  cmd_bank = '0;
  logic        bg_en = 1'b0;
  logic        err_clr = 1'b0;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [3:0]  err_bank;
  logic [6:0]  err_status;
  logic [15:0] err_count;

  gddr6_bank_timing_checker dut (
    .CLK_t      (CLK_t),
    .RESET_n    (RESET_n),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_bank   (cmd_bank),
    .bg_en      (bg_en),
    .err_clr    (err_clr),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_bank   (err_bank),
    .err_status (err_status),
    .err_count  (err_count)
  );

  always #5 CLK_t = ~CLK_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: absolute command times instead of counters.
  int   m_now;
  bit   m_active [NB];
  int   t_act [NB];
  int   t_pre [NB];
  int   t_col_bg [NB/4];
  int   t_col, t_act_any, m_last_bank;
  bit   m_valid;
  int   m_code, m_bank, m_status, m_count;

  typedef struct {
    bit         rst;
    bit         bg;
    int         gap;
    bit         v;
    logic [4:0] code;
    int         bank;
    bit         clr;
    bit         ev;
    int         ecode;
    int         ebank;
    int         estatus;
    int         ecount;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_active[b] = 0;
      t_act[b] = NONE;
      t_pre[b] = NONE;
    end
    for (int g = 0; g < NB/4; g++) t_col_bg[g] = NONE;
    t_col = NONE;
    t_act_any = NONE;
    m_last_bank = 0;
    m_valid = 0;
    m_code = 0;
    m_bank = 0;
    m_status = 0;
    m_count = 0;
  endtask

  task automatic model_cmd(input bit v, input logic [4:0] c, input int b, input bit clr);
    bit [6:0] vb;
    int ob;
    vb = '0;
    ob = b;
    if (v && (c == RD || c == RDA || c == WOM || c == WOMA)) begin
      if (!m_active[b]) vb[1] = 1;
      if (m_now - t_act[b] < T_RCD) vb[2] = 1;
      if (m_now - t_col < T_CCD_S || (bg_en && m_now - t_col_bg[b/4] < T_CCD_L)) vb[3] = 1;
      t_col = m_now;
      t_col_bg[b/4] = m_now;
      if (c == RDA || c == WOMA) begin
        m_active[b] = 0;
        t_pre[b] = m_now;
      end
    end else if (v && c == ACT) begin
      if (m_active[b]) vb[1] = 1;
      if (m_now - t_pre[b] < T_RP) vb[4] = 1;
      if (b != m_last_bank && m_now - t_act_any < T_RRD) vb[6] = 1;
      m_active[b] = 1;
      t_act[b] = m_now;
      t_act_any = m_now;
      m_last_bank = b;
    end else if (v && c == PRE) begin
      if (m_active[b]) begin
        if (m_now - t_act[b] < T_RAS) vb[5] = 1;
        m_active[b] = 0;
        t_pre[b] = m_now;
      end
    end else if (v && c == PREA) begin
      ob = -1;
      for (int bb = 0; bb < NB; bb++) begin
        if (m_active[bb]) begin
          if (m_now - t_act[bb] < T_RAS) begin
            vb[5] = 1;
            if (ob < 0) ob = bb;
          end
          m_active[bb] = 0;
          t_pre[bb] = m_now;
        end
      end
    end
    m_valid = (vb != 0);
    m_code = 0;
    for (int i = 1; i <= 6; i++) if (vb[i] && m_code == 0) m_code = i;
    m_bank = ob;
    if (clr) begin
      m_status = int'(vb);
      m_count = m_valid ? 1 : 0;
    end else begin
      m_status = m_status | int'(vb);
      if (m_valid && m_count < 65535) m_count++;
    end
    m_now++;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input bit v, input logic [4:0] c, input int b, input bit clr);
    cmd_valid = v;
    cmd_code = c;
    cmd_bank = 4'(b);
    err_clr = clr;
    @(posedge CLK_t);
    #1;
    model_cmd(v, c, b, clr);
    check("mdl_valid", 32'(err_valid), 32'(m_valid));
    if (m_valid) begin
      check("mdl_code", 32'(err_code), 32'(m_code));
      check("mdl_bank", 32'(err_bank), 32'(m_bank));
    end
    check("mdl_status", 32'(err_status), 32'(m_status));
    check("mdl_count", 32'(err_count), 32'(m_count));
    cmd_valid = 0;
    cmd_code = NOP;
    err_clr = 0;
  endtask

  task automatic do_reset();
    RESET_n = 0;
    model_reset();
    @(posedge CLK_t);
    @(posedge CLK_t);
    #1;
    RESET_n = 1;
  endtask

  task automatic row(input bit rst, input bit bg, input int gap, input bit v, input logic [4:0] c,
                     input int b, input bit clr, input bit ev, input int ecode, input int ebank,
                     input int estatus, input int ecount);
    vec_t r;
    r.rst = rst; r.bg = bg; r.gap = gap; r.v = v; r.code = c; r.bank = b; r.clr = clr;
    r.ev = ev; r.ecode = ecode; r.ebank = ebank; r.estatus = estatus; r.ecount = ecount;
    tbl.push_back(r);
  endtask

  initial begin
    model_reset();
    m_now = 0;
    #2;
    check("reset_valid", 32'(err_valid), 0);
    check("reset_code", 32'(err_code), 0);
    check("reset_bank", 32'(err_bank), 0);
    check("reset_status", 32'(err_status), 0);
    check("reset_count", 32'(err_count), 0);
    @(posedge CLK_t);
    #1;
    RESET_n = 1;

    //  rst bg gap v code  bk clr  ev code bank status count
    // tRCD: legal at distance 12, violation at 11
    row(1, 0, 0,  1, ACT,  3, 0,   0, 0, 0, 'h00, 0);
    row(0, 0, 11, 1, RD,   3, 0,   0, 0, 0, 'h00, 0);
    row(1, 0, 0,  1, ACT,  3, 0,   0, 0, 0, 'h00, 0);
    row(0, 0, 10, 1, RD,   3, 0,   1, 2, 3, 'h04, 1);
    // tCCD_L in the same group; other group and bg_en=0 are legal at distance 2
    row(1, 1, 0,  1, ACT,  0, 0,   0, 0, 0, 'h00, 0);
    row(0, 1, 3,  1, ACT,  1, 0,   0, 0, 0, 'h00, 0);
    row(0, 1, 11, 1, RD,   0, 0,   0, 0, 0, 'h00, 0);
    row(0, 1, 2,  1, RD,   1, 0,   1, 3, 1, 'h08, 1);
    row(1, 1, 0,  1, ACT,  0, 0,   0, 0, 0, 'h00, 0);
    row(0, 1, 3,  1, ACT,  4, 0,   0, 0, 0, 'h00, 0);
    row(0, 1, 11, 1, RD,   0, 0,   0, 0, 0, 'h00, 0);
    row(0, 1, 1,  1, RD,   4, 0,   0, 0, 0, 'h00, 0);
    row(1, 0, 0,  1, ACT,  0, 0,   0, 0, 0, 'h00, 0);
    row(0, 0, 3,  1, ACT,  1, 0,   0, 0, 0, 'h00, 0);
    row(0, 0, 11, 1, RD,   0, 0,   0, 0, 0, 'h00, 0);
    row(0, 0, 1,  1, RD,   1, 0,   0, 0, 0, 'h00, 0);
    // protocol errors, sticky status across two violations
    row(1, 0, 0,  1, RD,   5, 0,   1, 1, 5, 'h02, 1);
    row(1, 0, 0,  1, ACT,  2, 0,   0, 0, 0, 'h00, 0);
    row(0, 0, 0,  1, ACT,  2, 0,   1, 1, 2, 'h02, 1);
    row(0, 0, 3,  1, RD,   2, 0,   1, 2, 2, 'h06, 2);
    // tRAS then tRP, and tRP met at exactly 12
    row(1, 0, 0,  1, ACT,  7, 0,   0, 0, 0, 'h00, 0);
    row(0, 0, 19, 1, PRE,  7, 0,   1, 5, 7, 'h20, 1);
    row(0, 0, 9,  1, ACT,  7, 0,   1, 4, 7, 'h30, 2);
    row(1, 0, 0,  1, ACT,  7, 0,   0, 0, 0, 'h00, 0);
    row(0, 0, 19, 1, PRE,  7, 0,   1, 5, 7, 'h20, 1);
    row(0, 0, 11, 1, ACT,  7, 0,   0, 0, 0, 'h20, 1);
    // PREab: lowest offending bank reported, all banks closed afterwards
    row(1, 0, 0,  1, ACT,  0, 0,   0, 0, 0, 'h00, 0);
    row(0, 0, 3,  1, ACT,  1, 0,   0, 0, 0, 'h00, 0);
    row(0, 0, 3,  1, ACT,  2, 0,   0, 0, 0, 'h00, 0);
    row(0, 0, 21, 1, PREA, 9, 0,   1, 5, 1, 'h20, 1);
    row(0, 0, 0,  1, RD,   0, 0,   1, 1, 0, 'h22, 2);
    row(0, 0, 0,  1, RD,   2, 0,   1, 1, 2, 'h2A, 3);
    // err_clr: a coinciding violation wins, a bare clear zeroes
    row(1, 0, 0,  1, RD,   5, 0,   1, 1, 5, 'h02, 1);
    row(0, 0, 0,  1, RD,   6, 1,   1, 1, 6, 'h0A, 1);
    row(0, 0, 0,  0, NOP,  0, 1,   0, 0, 0, 'h00, 0);
    row(0, 0, 0,  1, ACT,  1, 0,   0, 0, 0, 'h00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      bg_en = tbl[i].bg;
      repeat (tbl[i].gap) step(0, NOP, 0, 0);
      step(tbl[i].v, tbl[i].code, tbl[i].bank, tbl[i].clr);
      check($sformatf("row%0d_valid", i), 32'(err_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        check($sformatf("row%0d_code", i), 32'(err_code), 32'(tbl[i].ecode));
        check($sformatf("row%0d_bank", i), 32'(err_bank), 32'(tbl[i].ebank));
      end
      check($sformatf("row%0d_status", i), 32'(err_status), 32'(tbl[i].estatus));
      check($sformatf("row%0d_count", i), 32'(err_count), 32'(tbl[i].ecount));
    end

    // Asynchronous reset mid-sequence clears outputs at once and closes banks.
    bg_en = 0;
    do_reset();
    step(1, ACT, 0, 0);
    step(1, RD, 5, 0);
    check("pre_rst_valid", 32'(err_valid), 1);
    #2;
    RESET_n = 0;
    model_reset();
    #1;
    check("async_rst_valid", 32'(err_valid), 0);
    check("async_rst_code", 32'(err_code), 0);
    check("async_rst_status", 32'(err_status), 0);
    check("async_rst_count", 32'(err_count), 0);
    @(posedge CLK_t);
    #1;
    RESET_n = 1;
    step(1, RD, 0, 0);
    check("post_rst_prot_valid", 32'(err_valid), 1);
    check("post_rst_prot_code", 32'(err_code), 1);
    check("post_rst_prot_bank", 32'(err_bank), 0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int sel;
      logic [4:0] c;
      if (n % 250 == 0) bg_en = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 19);
      case (sel)
        0, 1, 2, 3: c = ACT;
        4, 5:       c = RD;
        6:          c = RDA;
        7:          c = WOM;
        8:          c = WOMA;
        9, 10:      c = PRE;
        11:         c = PREA;
        12:         c = 5'b11111;
        default:    c = NOP;
      endcase
      step(sel < 13 ? 1'b1 : 1'b0, c, $urandom_range(0, 7) * ($urandom_range(0, 3) == 0 ? 2 : 1),
           $urandom_range(0, 39) == 0 ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
